// File: rtl/bids_seq_pkg.sv
// Shared opcodes, engine error codes, sequencer state encodings and helpers
// for the bids22 round sequencer.
package bids_seq_pkg;

    typedef enum logic [3:0] {
        OP_NO_OP        = 4'd0,
        OP_UNLOCK       = 4'd1,
        OP_LOCK         = 4'd2,
        OP_LOADX        = 4'd3,
        OP_LOADY        = 4'd4,
        OP_LOADZ        = 4'd5,
        OP_SETMASK      = 4'd6,
        OP_SETTIMER     = 4'd7,
        OP_SETBIDCHARGE = 4'd8
    } c_op_e;

    localparam logic [3:0] ERR_NOERROR      = 4'h0;
    localparam logic [3:0] SEQ_TIMEOUT_CODE = 4'hF;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t S_IDLE      = 4'd0;
    localparam seq_state_t S_UNLK      = 4'd1;
    localparam seq_state_t S_LDX       = 4'd2;
    localparam seq_state_t S_LDY       = 4'd3;
    localparam seq_state_t S_LDZ       = 4'd4;
    localparam seq_state_t S_MSK       = 4'd5;
    localparam seq_state_t S_TMR       = 4'd6;
    localparam seq_state_t S_CHG       = 4'd7;
    localparam seq_state_t S_LCK       = 4'd8;
    localparam seq_state_t S_RUN       = 4'd9;
    localparam seq_state_t S_WAIT_OVER = 4'd10;
    localparam seq_state_t S_GAP       = 4'd11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bids_round_timer.sv
// Loadable down-counter with zero flag; used for round length and the
// optional WAIT_OVER watchdog.
module bids_round_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bids_round_sequencer.sv
// Host-side sequencer driving the bids22 control port: replays a descriptor
// as engine commands, then runs timed rounds. Optional: ROUNDSEQ_TIMEOUT_EN.
module bids_round_sequencer
    import bids_seq_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned NUMBIDDERS = 3,
    parameter int unsigned RNDW       = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [DATAWIDTH-1:0]             cfg_key,
    input  logic [NUMBIDDERS*DATAWIDTH-1:0]  cfg_bal,
    input  logic [NUMBIDDERS-1:0]            cfg_mask,
    input  logic [DATAWIDTH-1:0]             cfg_timer,
    input  logic [DATAWIDTH-1:0]             cfg_charge,
    input  logic [7:0]                       cfg_rounds,
    input  logic [RNDW-1:0]                  cfg_rndlen,
    output logic [3:0]                       c_op,
    output logic [DATAWIDTH-1:0]             c_data,
    output logic                             c_start,
    input  logic                             eng_ready,
    input  logic [3:0]                       eng_err,
    input  logic                             eng_round_over,
    input  logic [DATAWIDTH-1:0]             eng_max_bid,
    output logic                             res_valid,
    output logic [DATAWIDTH-1:0]             res_max_bid,
    output logic [7:0]                       rounds_done,
    output logic                             busy,
    output logic                             done,
    output logic                             seq_err,
    output logic [3:0]                       seq_err_code
);

    generate
        if (NUMBIDDERS != 3) begin : g_bidder_check
            $error("bids_round_sequencer: NUMBIDDERS must be 3 (LOADX/LOADY/LOADZ only)");
        end
    endgenerate

    seq_state_t                      state;
    logic [DATAWIDTH-1:0]            cfg_key_q;
    logic [NUMBIDDERS*DATAWIDTH-1:0] cfg_bal_q;
    logic [NUMBIDDERS-1:0]           cfg_mask_q;
    logic [DATAWIDTH-1:0]            cfg_timer_q;
    logic [DATAWIDTH-1:0]            cfg_charge_q;
    logic [7:0]                      cfg_rounds_q;
    logic [RNDW-1:0]                 cfg_rndlen_q;
    logic [DATAWIDTH-1:0]            key_q;
    logic                            locked;
    logic                            issued_q;

    logic            cmd_state;
    logic            err_now;
    logic            issue;
    logic            run_load;
    logic [RNDW-1:0] run_load_val;
    logic            run_zero;
    logic            run_end;
    logic            wd_expire;

    assign cmd_state = (state >= S_UNLK) && (state <= S_LCK);
    // An error reported for the previous command cancels whatever would issue now.
    assign err_now   = issued_q && (eng_err != ERR_NOERROR);
    assign issue     = cmd_state && eng_ready && !err_now;
    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign c_start   = (state == S_RUN) && !err_now;
    assign run_end   = (state == S_RUN) && run_zero && !err_now;

    assign run_load     = (issue && (state == S_LCK) && (cfg_rounds_q != 8'd0)) ||
                          ((state == S_GAP) && eng_ready);
    assign run_load_val = (cfg_rndlen_q == '0) ? '0 : cfg_rndlen_q - 1'b1;

    bids_round_timer #(.W(RNDW)) u_run_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (run_load),
        .load_val (run_load_val),
        .dec      (state == S_RUN),
        .zero     (run_zero)
    );

`ifdef ROUNDSEQ_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic wd_zero;

    bids_round_timer #(.W(WDW)) u_wd_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (run_end),
        .load_val (WDW'(TIMEOUT - 1)),
        .dec      (state == S_WAIT_OVER),
        .zero     (wd_zero)
    );

    assign wd_expire = (state == S_WAIT_OVER) && !eng_round_over && wd_zero;
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        c_op   = OP_NO_OP;
        c_data = '0;
        if (issue) begin
            case (state)
                S_UNLK: begin c_op = OP_UNLOCK;       c_data = key_q;                           end
                S_LDX:  begin c_op = OP_LOADX;        c_data = cfg_bal_q[0*DATAWIDTH +: DATAWIDTH]; end
                S_LDY:  begin c_op = OP_LOADY;        c_data = cfg_bal_q[1*DATAWIDTH +: DATAWIDTH]; end
                S_LDZ:  begin c_op = OP_LOADZ;        c_data = cfg_bal_q[2*DATAWIDTH +: DATAWIDTH]; end
                S_MSK:  begin c_op = OP_SETMASK;      c_data[NUMBIDDERS-1:0] = cfg_mask_q;      end
                S_TMR:  begin c_op = OP_SETTIMER;     c_data = cfg_timer_q;                     end
                S_CHG:  begin c_op = OP_SETBIDCHARGE; c_data = cfg_charge_q;                    end
                S_LCK:  begin c_op = OP_LOCK;         c_data = cfg_key_q;                       end
                default: begin c_op = OP_NO_OP;       c_data = '0;                              end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cfg_key_q    <= '0;
            cfg_bal_q    <= '0;
            cfg_mask_q   <= '0;
            cfg_timer_q  <= '0;
            cfg_charge_q <= '0;
            cfg_rounds_q <= '0;
            cfg_rndlen_q <= '0;
            key_q        <= '0;
            locked       <= 1'b0;
            issued_q     <= 1'b0;
            res_valid    <= 1'b0;
            res_max_bid  <= '0;
            rounds_done  <= '0;
            done         <= 1'b0;
            seq_err      <= 1'b0;
            seq_err_code <= '0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            issued_q  <= issue;

            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        cfg_key_q    <= cfg_key;
                        cfg_bal_q    <= cfg_bal;
                        cfg_mask_q   <= cfg_mask;
                        cfg_timer_q  <= cfg_timer;
                        cfg_charge_q <= cfg_charge;
                        cfg_rounds_q <= cfg_rounds;
                        cfg_rndlen_q <= cfg_rndlen;
                        seq_err      <= 1'b0;
                        seq_err_code <= '0;
                        rounds_done  <= '0;
                        state        <= locked ? S_UNLK : S_LDX;
                    end
                end
                S_UNLK: if (issue) begin locked <= 1'b0; state <= S_LDX; end
                S_LDX:  if (issue) state <= S_LDY;
                S_LDY:  if (issue) state <= S_LDZ;
                S_LDZ:  if (issue) state <= S_MSK;
                S_MSK:  if (issue) state <= S_TMR;
                S_TMR:  if (issue) state <= S_CHG;
                S_CHG:  if (issue) state <= S_LCK;
                S_LCK: begin
                    if (issue) begin
                        locked <= 1'b1;
                        key_q  <= cfg_key_q;
                        if (cfg_rounds_q == 8'd0) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: if (run_end) state <= S_WAIT_OVER;
                S_WAIT_OVER: begin
                    if (eng_round_over) begin
                        res_max_bid <= eng_max_bid;
                        res_valid   <= 1'b1;
                        rounds_done <= sat_inc8(rounds_done);
                        if (({1'b0, rounds_done} + 9'd1) == {1'b0, cfg_rounds_q}) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (wd_expire) begin
                        seq_err      <= 1'b1;
                        seq_err_code <= SEQ_TIMEOUT_CODE;
                        state        <= S_IDLE;
                    end
                end
                S_GAP: if (eng_ready) state <= S_RUN;
                default: state <= S_IDLE;
            endcase

            if (err_now) begin
                seq_err      <= 1'b1;
                seq_err_code <= eng_err;
                if (state != S_IDLE) state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bids_round_sequencer.sv
// Self-checking bench for bids_round_sequencer: descriptor table plus
// command/run/result scoreboards and a mid-sequence reset sequence.
module tb_bids_round_sequencer;
    import bids_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_key;
    logic [95:0] cfg_bal;
    logic [2:0]  cfg_mask;
    logic [31:0] cfg_timer;
    logic [31:0] cfg_charge;
    logic [7:0]  cfg_rounds;
    logic [15:0] cfg_rndlen;
    logic [3:0]  c_op;
    logic [31:0] c_data;
    logic        c_start;
    logic        eng_ready;
    logic [3:0]  eng_err;
    logic        eng_round_over;
    logic [31:0] eng_max_bid;
    logic        res_valid;
    logic [31:0] res_max_bid;
    logic [7:0]  rounds_done;
    logic        busy;
    logic        done;
    logic        seq_err;
    logic [3:0]  seq_err_code;

    always #5 clk = ~clk;

    bids_round_sequencer #(.DATAWIDTH(32), .NUMBIDDERS(3), .RNDW(16), .TIMEOUT(1024)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_bal(cfg_bal),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_charge(cfg_charge),
        .cfg_rounds(cfg_rounds), .cfg_rndlen(cfg_rndlen),
        .c_op(c_op), .c_data(c_data), .c_start(c_start),
        .eng_ready(eng_ready), .eng_err(eng_err), .eng_round_over(eng_round_over),
        .eng_max_bid(eng_max_bid),
        .res_valid(res_valid), .res_max_bid(res_max_bid), .rounds_done(rounds_done),
        .busy(busy), .done(done), .seq_err(seq_err), .seq_err_code(seq_err_code)
    );

    typedef struct {
        logic [31:0] key;
        logic [31:0] b0, b1, b2;
        logic [2:0]  mask;
        logic [31:0] tmr, chg;
        logic [7:0]  rounds;
        logic [15:0] rndlen;
        logic [31:0] maxbid;
        logic [3:0]  err_op;
        logic [3:0]  err_code;
        logic [3:0]  stall_after;
        int          exp_done;
        logic [7:0]  exp_rounds;
        logic        exp_err;
        logic [3:0]  exp_code;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] data;
    } cmd_t;

    vec_t        vecs[5];
    cmd_t        cmd_q[$];
    int          run_q[$];
    logic [31:0] res_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          model_locked = 1'b0;
    logic [31:0] model_key = '0;
    int          cyc = 0;
    int          lock_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          cur_run = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] key, b0, b1, b2, input logic [2:0] mask,
                                input logic [31:0] tmr, chg, input logic [7:0] rounds,
                                input logic [15:0] rndlen, input logic [31:0] maxbid,
                                input logic [3:0] err_op, err_code, stall_after,
                                input int exp_done, input logic [7:0] exp_rounds,
                                input logic exp_err, input logic [3:0] exp_code);
        vec_t v;
        v.key = key; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.mask = mask;
        v.tmr = tmr; v.chg = chg; v.rounds = rounds; v.rndlen = rndlen; v.maxbid = maxbid;
        v.err_op = err_op; v.err_code = err_code; v.stall_after = stall_after;
        v.exp_done = exp_done; v.exp_rounds = exp_rounds; v.exp_err = exp_err; v.exp_code = exp_code;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard side: consumes expected commands, run lengths and results as the DUT produces them.
    always @(negedge clk) begin
        cmd_t e;
        if (reset_n) begin
            if (c_op != 4'd0) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got op=%0d data=%0h, required no command", c_op, c_data);
                end else begin
                    e = cmd_q.pop_front();
                    checks++;
                    if (c_op !== e.op || c_data !== e.data) begin
                        errors++;
                        $display("FAIL cmd: got op=%0d data=%0h, required op=%0d data=%0h",
                                 c_op, c_data, e.op, e.data);
                    end
                end
                if (c_op == OP_LOCK) lock_cyc = cyc;
            end
            if (c_start) begin
                cur_run++;
                chk("op_during_start", {28'd0, c_op}, 32'd0);
            end else if (cur_run > 0) begin
                if (run_q.size() == 0) chk("run_unexpected", cur_run, 0);
                else chk("run_len", cur_run, run_q.pop_front());
                cur_run = 0;
            end
            if (res_valid) begin
                if (res_q.size() == 0) chk("res_unexpected", res_max_bid, 32'hFFFF_FFFF);
                else chk("res_max_bid", res_max_bid, res_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic build_expect(input vec_t v);
        cmd_t list[$];
        cmd_t c;
        if (model_locked) begin c.op = OP_UNLOCK; c.data = model_key; list.push_back(c); end
        c.op = OP_LOADX;        c.data = v.b0;            list.push_back(c);
        c.op = OP_LOADY;        c.data = v.b1;            list.push_back(c);
        c.op = OP_LOADZ;        c.data = v.b2;            list.push_back(c);
        c.op = OP_SETMASK;      c.data = {29'd0, v.mask}; list.push_back(c);
        c.op = OP_SETTIMER;     c.data = v.tmr;           list.push_back(c);
        c.op = OP_SETBIDCHARGE; c.data = v.chg;           list.push_back(c);
        c.op = OP_LOCK;         c.data = v.key;           list.push_back(c);
        foreach (list[i]) begin
            cmd_q.push_back(list[i]);
            if (list[i].op == OP_UNLOCK) model_locked = 1'b0;
            if (list[i].op == OP_LOCK) begin model_locked = 1'b1; model_key = v.key; end
            if (v.err_op != 4'd0 && list[i].op == v.err_op) break;
        end
        if (v.err_op == 4'd0) begin
            for (int r = 0; r < int'(v.rounds); r++) begin
                run_q.push_back((v.rndlen == 16'd0) ? 1 : int'(v.rndlen));
                res_q.push_back(v.maxbid + r);
            end
        end
    endtask

    task automatic accept(input vec_t v);
        @(posedge clk); #1;
        cfg_key = v.key; cfg_bal = {v.b2, v.b1, v.b0}; cfg_mask = v.mask;
        cfg_timer = v.tmr; cfg_charge = v.chg; cfg_rounds = v.rounds; cfg_rndlen = v.rndlen;
        cfg_valid = 1'b1;
        #1 chk("cfg_ready_before_accept", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Plays the engine: stalls, error injection and round_over responses.
    task automatic run_loop(input vec_t v);
        int stall_left = 0;
        bit stalled = 1'b0, st, err_pend = 1'b0, ro_pend = 1'b0, prev_start = 1'b0, fin = 1'b0;
        int rnd = 0;
        for (int k = 0; k < 600; k++) begin
            st = (stall_left > 0);
            eng_ready = !st;
            if (st) stall_left--;
            eng_err = err_pend ? v.err_code : 4'd0;
            err_pend = 1'b0;
            eng_round_over = ro_pend;
            eng_max_bid = ro_pend ? v.maxbid + rnd : 32'd0;
            if (ro_pend) rnd++;
            ro_pend = 1'b0;
            #1;
            if (st) chk("stall_noop", {28'd0, c_op}, 32'd0);
            if (v.stall_after != 4'd0 && !stalled && c_op == v.stall_after) begin
                stall_left = 4; stalled = 1'b1;
            end
            if (v.err_op != 4'd0 && c_op == v.err_op) err_pend = 1'b1;
            if (prev_start && !c_start && busy) ro_pend = 1'b1;
            prev_start = c_start;
            if (done || seq_err) begin fin = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!fin) chk("descriptor_budget", 32'd0, 32'd1);
        @(posedge clk); #1;
        eng_ready = 1'b1; eng_err = 4'd0; eng_round_over = 1'b0; eng_max_bid = '0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic finish_vec(input vec_t v, input int d0);
        chk("done_count", done_cnt - d0, v.exp_done);
        chk("rounds_done", rounds_done, v.exp_rounds);
        chk("seq_err", seq_err, v.exp_err);
        chk("seq_err_code", seq_err_code, v.exp_code);
        chk("busy_idle", busy, 0);
        chk("cfg_ready_idle", cfg_ready, 1);
        chk("cmd_q_left", cmd_q.size(), 0);
        chk("run_q_left", run_q.size(), 0);
        chk("res_q_left", res_q.size(), 0);
        if (v.rounds == 8'd0 && v.err_op == 4'd0) chk("done_after_lock", done_cyc - lock_cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        vecs[0] = mk(32'd5,   32'd100, 32'd200, 32'd300, 3'b101, 32'd4, 32'd2, 8'd1, 16'd3, 32'd42,
                     4'd0, 4'd0, 4'd0, 1, 8'd1, 1'b0, 4'd0);
        vecs[1] = mk(32'd9,   32'd1,   32'd2,   32'd3,   3'b111, 32'd7, 32'd1, 8'd2, 16'd2, 32'd50,
                     4'd0, 4'd0, 4'd4, 1, 8'd2, 1'b0, 4'd0);
        vecs[2] = mk(32'h11,  32'd10,  32'd20,  32'd30,  3'b011, 32'd1, 32'd1, 8'd1, 16'd1, 32'd0,
                     4'd6, 4'd3, 4'd0, 0, 8'd0, 1'b1, 4'd3);
        vecs[3] = mk(32'h22,  32'd4,   32'd5,   32'd6,   3'b001, 32'd2, 32'd3, 8'd3, 16'd0, 32'd7,
                     4'd0, 4'd0, 4'd0, 1, 8'd3, 1'b0, 4'd0);
        vecs[4] = mk(32'h33,  32'd7,   32'd8,   32'd9,   3'b010, 32'd0, 32'd0, 8'd0, 16'd5, 32'd0,
                     4'd0, 4'd0, 4'd0, 1, 8'd0, 1'b0, 4'd0);

        reset_n = 1'b0; cfg_valid = 1'b0; cfg_key = '0; cfg_bal = '0; cfg_mask = '0;
        cfg_timer = '0; cfg_charge = '0; cfg_rounds = '0; cfg_rndlen = '0;
        eng_ready = 1'b1; eng_err = '0; eng_round_over = 1'b0; eng_max_bid = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_c_op", {28'd0, c_op}, 0);
        chk("rst_c_data", c_data, 0);
        chk("rst_c_start", c_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_max_bid", res_max_bid, 0);
        chk("rst_rounds_done", rounds_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_seq_err_code", seq_err_code, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            build_expect(vecs[i]);
            accept(vecs[i]);
            run_loop(vecs[i]);
            finish_vec(vecs[i], d0);
        end

        // Reset while the engine is locked and a new descriptor is mid-replay.
        build_expect(vecs[0]);
        accept(vecs[0]);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_c_op", {28'd0, c_op}, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        cmd_q.delete(); run_q.delete(); res_q.delete();
        model_locked = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        d0 = done_cnt;
        build_expect(vecs[0]);
        accept(vecs[0]);
        run_loop(vecs[0]);
        finish_vec(vecs[0], d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
